// File: rtl/board_controller.sv
// Five-by-five N-in-a-row game controller: cursor and placement FSM, serial win scan
// over start cells, and board/cursor display registers that update once per frame.
module board_controller #(
  parameter int N_WIN = 4
) (
  input  logic        dclk,
  input  logic        clr,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_sel,
  input  logic        btn_new,
  input  logic        vsync,
  output logic [74:0] board_flat,
  output logic [2:0]  cursor_row,
  output logic [2:0]  cursor_col,
  output logic [1:0]  cur_player,
  output logic [1:0]  winner,
  output logic        busy
);

  typedef enum logic [1:0] {PLAY, CHECK, OVER} state_t;
  typedef logic [1:0] board_t [25];

  state_t      r_state, w_next;
  board_t      r_board;
  logic [2:0]  r_row, r_col;
  logic [2:0]  r_scan_row, r_scan_col;
  logic [1:0]  r_player, r_winner;
  logic        r_vsync_prev;
  logic [74:0] r_disp_board;
  logic [2:0]  r_disp_row, r_disp_col;

  logic [4:0]  w_cur_idx;
  logic [74:0] w_board_pack;
  logic        w_cell_empty, w_full, w_hit, w_scan_last;
  logic        w_place, w_move_en, w_vs_fall;

  // True when N_WIN cells from (row,col) stepping (dr,dc) stay on the grid and all hold p.
  function automatic logic run_from(input board_t b, input logic [1:0] p,
                                    input logic [2:0] row, input logic [2:0] col,
                                    input int dr, input int dc);
    int   rr, cc;
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < N_WIN; k++) begin
      rr = int'(row) + k * dr;
      cc = int'(col) + k * dc;
      if (rr < 0 || rr > 4 || cc < 0 || cc > 4) ok = 1'b0;
      else if (b[5'(rr * 5 + cc)] != p)          ok = 1'b0;
    end
    return ok;
  endfunction

  assign w_cur_idx    = {2'b00, r_row} * 5'd5 + {2'b00, r_col};
  assign w_cell_empty = (r_board[w_cur_idx] == 2'd0);
  assign w_scan_last  = (r_scan_row == 3'd4) && (r_scan_col == 3'd4);
  assign w_vs_fall    = r_vsync_prev & ~vsync;
  assign w_hit        = run_from(r_board, r_player, r_scan_row, r_scan_col, 0, 1)
                      | run_from(r_board, r_player, r_scan_row, r_scan_col, 1, 0)
                      | run_from(r_board, r_player, r_scan_row, r_scan_col, 1, 1)
                      | run_from(r_board, r_player, r_scan_row, r_scan_col, 1, -1);

  always_comb begin
    w_full = 1'b1;
    for (int i = 0; i < 25; i++)
      if (r_board[i] == 2'd0) w_full = 1'b0;
  end

  for (genvar g = 0; g < 25; g++) begin : g_pack
    assign w_board_pack[g*3 +: 3] = {1'b0, r_board[g]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) r_state <= PLAY;
    else     r_state <= w_next;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves w_next unassigned and infers a latch.
    w_next = r_state;
    if (btn_new) w_next = PLAY;
    else begin
      case (r_state)
        PLAY:    if (btn_sel && w_cell_empty) w_next = CHECK;
        CHECK:   if (w_hit)            w_next = OVER;
                 else if (w_scan_last) w_next = w_full ? OVER : PLAY;
        OVER:    w_next = OVER;
        default: w_next = PLAY;
      endcase
    end
  end

  always_comb begin
    busy      = (r_state == CHECK);
    w_place   = (r_state == PLAY) && !btn_new && btn_sel && w_cell_empty;
    w_move_en = (r_state == PLAY) && !btn_new && !btn_sel;
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      // NOTE: the board array is reset explicitly because placement legality depends on empty cells.
      for (int i = 0; i < 25; i++) r_board[i] <= 2'd0;
      r_row      <= 3'd2;
      r_col      <= 3'd2;
      r_player   <= 2'd1;
      r_winner   <= 2'd0;
      r_scan_row <= 3'd0;
      r_scan_col <= 3'd0;
    end else if (btn_new) begin
      for (int i = 0; i < 25; i++) r_board[i] <= 2'd0;
      r_row      <= 3'd2;
      r_col      <= 3'd2;
      r_player   <= 2'd1;
      r_winner   <= 2'd0;
      r_scan_row <= 3'd0;
      r_scan_col <= 3'd0;
    end else begin
      if (w_place) begin
        r_board[w_cur_idx] <= r_player;
        r_scan_row         <= 3'd0;
        r_scan_col         <= 3'd0;
      end else if (w_move_en) begin
        if (btn_up)         begin if (r_row != 3'd0) r_row <= r_row - 3'd1; end
        else if (btn_down)  begin if (r_row != 3'd4) r_row <= r_row + 3'd1; end
        else if (btn_left)  begin if (r_col != 3'd0) r_col <= r_col - 3'd1; end
        else if (btn_right) begin if (r_col != 3'd4) r_col <= r_col + 3'd1; end
      end
      if (busy) begin
        if (w_hit) r_winner <= r_player;
        else if (w_scan_last) begin
          if (w_full) r_winner <= 2'd3;
          else        r_player <= (r_player == 2'd1) ? 2'd2 : 2'd1;
        end else if (r_scan_col == 3'd4) begin
          r_scan_col <= 3'd0;
          r_scan_row <= r_scan_row + 3'd1;
        end else begin
          r_scan_col <= r_scan_col + 3'd1;
        end
      end
    end
  end

  // Display copies are taken only on a vsync falling edge so a frame never shows a torn board.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      r_vsync_prev <= 1'b1;
      r_disp_board <= '0;
      r_disp_row   <= 3'd2;
      r_disp_col   <= 3'd2;
    end else begin
      r_vsync_prev <= vsync;
      if (w_vs_fall) begin
        r_disp_board <= w_board_pack;
        r_disp_row   <= r_row;
        r_disp_col   <= r_col;
      end
    end
  end

  assign board_flat = r_disp_board;
  assign cursor_row = r_disp_row;
  assign cursor_col = r_disp_col;
  assign cur_player = r_player;
  assign winner     = r_winner;

endmodule

// File: tb/tb_board_controller.sv
// Scoreboard bench for board_controller: a behavioural game model pushes expected
// results as buttons are driven; they are popped when the DUT settles or a frame is shown.
module tb_board_controller;

  localparam int N_WIN = 4;

  logic        dclk = 1'b0;
  logic        clr;
  logic        btn_up, btn_down, btn_left, btn_right, btn_sel, btn_new;
  logic        vsync;
  logic [74:0] board_flat;
  logic [2:0]  cursor_row, cursor_col;
  logic [1:0]  cur_player, winner;
  logic        busy;

  board_controller #(.N_WIN(N_WIN)) dut (
    .dclk(dclk), .clr(clr),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_sel(btn_sel), .btn_new(btn_new), .vsync(vsync),
    .board_flat(board_flat), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .cur_player(cur_player), .winner(winner), .busy(busy)
  );

  always #5 dclk = ~dclk;

  typedef struct {
    string       tag;
    logic [79:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [1:0]  m_board [25];
  int          m_row, m_col;
  logic [1:0]  m_player, m_winner;
  bit          m_over;
  logic [74:0] m_disp_board;
  int          m_disp_row, m_disp_col;
  int          q1[$], q2[$];

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [79:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input logic [79:0] got);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_underflow: got %0h, expected nothing pending", got);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, got, e.val);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 25; i++) m_board[i] = 2'd0;
    m_row = 2; m_col = 2;
    m_player = 2'd1; m_winner = 2'd0; m_over = 1'b0;
  endtask

  function automatic logic [74:0] pack_model();
    logic [74:0] p;
    p = '0;
    for (int i = 0; i < 25; i++) p[i*3 +: 3] = {1'b0, m_board[i]};
    return p;
  endfunction

  function automatic bit model_full();
    for (int i = 0; i < 25; i++) if (m_board[i] == 2'd0) return 1'b0;
    return 1'b1;
  endfunction

  // Lowest start cell holding an on-grid E/S/SE/SW run of the mover, or -1.
  function automatic int first_win();
    int dr, dc, rr, cc;
    bit ok;
    for (int s = 0; s < 25; s++) begin
      for (int d = 0; d < 4; d++) begin
        dr = (d == 0) ? 0 : 1;
        dc = (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
        ok = 1'b1;
        for (int k = 0; k < N_WIN; k++) begin
          rr = s / 5 + k * dr;
          cc = s % 5 + k * dc;
          if (rr < 0 || rr > 4 || cc < 0 || cc > 4) ok = 1'b0;
          else if (m_board[rr*5 + cc] != m_player)  ok = 1'b0;
        end
        if (ok) return s;
      end
    end
    return -1;
  endfunction

  task automatic press(input int b);
    @(negedge dclk);
    case (b)
      0:       btn_up    = 1'b1;
      1:       btn_down  = 1'b1;
      2:       btn_left  = 1'b1;
      default: btn_right = 1'b1;
    endcase
    @(negedge dclk);
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    if (!m_over) begin
      case (b)
        0:       if (m_row > 0) m_row--;
        1:       if (m_row < 4) m_row++;
        2:       if (m_col > 0) m_col--;
        default: if (m_col < 4) m_col++;
      endcase
    end
  endtask

  task automatic move_to(input int r, input int c);
    int dr, dc;
    dr = r - m_row;
    dc = c - m_col;
    repeat ((dr < 0) ? -dr : dr) press((dr < 0) ? 0 : 1);
    repeat ((dc < 0) ? -dc : dc) press((dc < 0) ? 2 : 3);
  endtask

  task automatic pulse_sel();
    @(negedge dclk); btn_sel = 1'b1;
    @(negedge dclk); btn_sel = 1'b0;
  endtask

  task automatic place(input int r, input int c);
    int k, cnt;
    move_to(r, c);
    if (!m_over && m_board[r*5 + c] == 2'd0) begin
      m_board[r*5 + c] = m_player;
      k = first_win();
      if (k >= 0) begin
        push("busy_cycles", 80'(k + 1));
        m_winner = m_player;
        m_over   = 1'b1;
      end else begin
        push("busy_cycles", 80'd25);
        if (model_full()) begin
          m_winner = 2'd3;
          m_over   = 1'b1;
        end else begin
          m_player = (m_player == 2'd1) ? 2'd2 : 2'd1;
        end
      end
    end else begin
      push("busy_cycles", 80'd0);
    end
    push("winner", 80'(m_winner));
    push("cur_player", 80'(m_player));
    pulse_sel();
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge dclk);
    end
    pop_check(80'(cnt));
    pop_check(80'(winner));
    pop_check(80'(cur_player));
  endtask

  task automatic frame();
    push("disp_cursor_hold", 80'({3'(m_disp_row), 3'(m_disp_col)}));
    pop_check(80'({cursor_row, cursor_col}));
    m_disp_board = pack_model();
    m_disp_row   = m_row;
    m_disp_col   = m_col;
    push("disp_board", 80'(m_disp_board));
    push("disp_cursor", 80'({3'(m_disp_row), 3'(m_disp_col)}));
    @(negedge dclk); vsync = 1'b0;
    @(negedge dclk); vsync = 1'b1;
    pop_check(80'(board_flat));
    pop_check(80'({cursor_row, cursor_col}));
  endtask

  task automatic new_game();
    @(negedge dclk); btn_new = 1'b1;
    @(negedge dclk); btn_new = 1'b0;
    model_reset();
  endtask

  task automatic idle_status(input string pfx);
    push({pfx, "_busy"}, 80'd0);
    push({pfx, "_winner"}, 80'(m_winner));
    push({pfx, "_player"}, 80'(m_player));
    pop_check(80'(busy));
    pop_check(80'(winner));
    pop_check(80'(cur_player));
  endtask

  task automatic reset_display_model();
    m_disp_board = '0;
    m_disp_row   = 2;
    m_disp_col   = 2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1;
    {btn_up, btn_down, btn_left, btn_right, btn_sel, btn_new} = 6'b0;
    vsync = 1'b1;
    model_reset();
    reset_display_model();
    repeat (3) @(negedge dclk);

    // Held in reset
    push("rst_board", 80'd0);
    push("rst_cursor", 80'({3'd2, 3'd2}));
    pop_check(80'(board_flat));
    pop_check(80'({cursor_row, cursor_col}));
    idle_status("rst");
    clr = 1'b0;
    @(negedge dclk);

    // Cursor saturation at the top-left corner; display waits for the frame
    repeat (3) press(0);
    repeat (3) press(2);
    frame();

    // First placement, then a repeat on the occupied cell
    place(2, 2);
    frame();
    place(2, 2);

    // Row win for player 1 at start cell 0; OVER ignores further input
    new_game();
    place(0, 0); place(4, 0); place(0, 1); place(4, 1);
    place(0, 2); place(3, 4); place(0, 3);
    place(3, 3);
    press(1);
    frame();

    // SW diagonal win for player 2
    new_game();
    place(0, 0); place(0, 4); place(1, 0); place(1, 3);
    place(3, 3); place(2, 2); place(4, 4); place(3, 1);
    frame();

    // East run that would only exist by wrapping rows
    new_game();
    place(1, 3); place(4, 0); place(1, 4); place(4, 2);
    place(2, 0); place(3, 4); place(2, 1);
    frame();

    // Full board with no run of four -> draw
    new_game();
    for (int s = 0; s < 25; s++) begin
      if (((s % 5 == 2) || (s % 5 == 3)) != ((s / 5) % 2 == 1)) q2.push_back(s);
      else                                                       q1.push_back(s);
    end
    for (int i = 0; i < 13; i++) begin
      place(q1[i] / 5, q1[i] % 5);
      if (i < 12) place(q2[i] / 5, q2[i] % 5);
    end
    frame();

    // btn_new with btn_sel mid-scan aborts back to a fresh game
    new_game();
    move_to(1, 1);
    pulse_sel();
    repeat (3) @(negedge dclk);
    push("midcheck_busy", 80'd1);
    pop_check(80'(busy));
    btn_new = 1'b1; btn_sel = 1'b1;
    @(negedge dclk);
    btn_new = 1'b0; btn_sel = 1'b0;
    model_reset();
    idle_status("new_abort");
    frame();

    // clr mid-scan restores every reset value, then play resumes
    move_to(0, 0);
    pulse_sel();
    m_board[0] = m_player;
    frame();
    push("clr_pre_busy", 80'd1);
    pop_check(80'(busy));
    clr = 1'b1;
    @(negedge dclk);
    model_reset();
    reset_display_model();
    push("clr_board", 80'd0);
    push("clr_cursor", 80'({3'd2, 3'd2}));
    pop_check(80'(board_flat));
    pop_check(80'({cursor_row, cursor_col}));
    idle_status("clr_abort");
    clr = 1'b0;
    @(negedge dclk);
    place(0, 0);
    frame();

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
